// File: rtl/led_pattern_if.sv
// Switch-side controls and LED-side outputs of the pattern engine, bundled as one port.
interface led_pattern_if #(
    parameter int N_LED      = 4,
    parameter int SPEED_BITS = 2
);
    logic [1:0]            mode;
    logic [SPEED_BITS-1:0] speed;
    logic                  pause;
    logic [N_LED-1:0]      led;
    logic                  tick;

    modport master (
        output mode,
        output speed,
        output pause,
        input  led,
        input  tick
    );

    modport slave (
        input  mode,
        input  speed,
        input  pause,
        output led,
        output tick
    );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern engine: a speed-scaled prescaler emits a step tick that advances one of
// four N_LED-wide patterns (count, walk, bounce, blink); mode/pause come from switches.
module led_pattern_gen #(
    parameter int N_LED      = 4,
    parameter int TICK_BASE  = 25_000_000,
    parameter int SPEED_BITS = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    led_pattern_if.slave bus
);

    // Counter must span the slowest period, TICK_BASE << (2**SPEED_BITS - 1).
    localparam int CW = $clog2(TICK_BASE << (2**SPEED_BITS - 1));

    localparam logic [CW:0] BASE = (CW+1)'(TICK_BASE);

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    if (N_LED < 1) begin : g_bad_n_led
        $error("led_pattern_gen: N_LED must be >= 1");
    end
    if (TICK_BASE < 2) begin : g_bad_tick_base
        $error("led_pattern_gen: TICK_BASE must be >= 2");
    end

    logic [CW-1:0]    cnt_q,  cnt_d;
    logic [N_LED-1:0] pat_q,  pat_d;
    dir_e             dir_q,  dir_d;
    mode_e            mode_q, mode_d;
    logic             tick_q, tick_d;

    mode_e       mode_in;
    logic [CW:0] period;
    logic [CW:0] term;
    logic        at_term;

    function automatic logic [N_LED-1:0] init_pat(input mode_e m);
        logic [N_LED-1:0] r;
        case (m)
            MODE_WALK,
            MODE_BOUNCE: r = N_LED'(1);
            default:     r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [N_LED-1:0] rotl(input logic [N_LED-1:0] p);
        return (p << 1) | (p >> (N_LED - 1));
    endfunction

    assign mode_in = mode_e'(bus.mode);

    // Period follows the live speed input, so a faster setting applies immediately;
    // the >= compare lets an over-range count terminate on the very next edge.
    assign period  = BASE << bus.speed;
    assign term    = period - (CW+1)'(1);
    assign at_term = ({1'b0, cnt_q} >= term);

    always_comb begin
        cnt_d  = cnt_q;
        pat_d  = pat_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        tick_d = 1'b0;

        if (mode_in != mode_q) begin
            mode_d = mode_in;
            pat_d  = init_pat(mode_in);
            dir_d  = DIR_UP;
            cnt_d  = '0;
        end else if (!bus.pause) begin
            if (at_term) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                case (mode_q)
                    MODE_COUNT: pat_d = pat_q + N_LED'(1);
                    MODE_WALK:  pat_d = rotl(pat_q);
                    MODE_BOUNCE: begin
                        // Direction flips on the step that lands on an end LED, so each
                        // end is shown for exactly one period.
                        if (N_LED == 1) begin
                            pat_d = N_LED'(1);
                        end else if (dir_q == DIR_UP) begin
                            pat_d = pat_q << 1;
                            if (pat_d[N_LED-1]) dir_d = DIR_DOWN;
                        end else begin
                            pat_d = pat_q >> 1;
                            if (pat_d[0]) dir_d = DIR_UP;
                        end
                    end
                    default:    pat_d = ~pat_q;
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pat_q  <= '0;
            dir_q  <= DIR_UP;
            mode_q <= MODE_COUNT;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pat_q  <= pat_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            tick_q <= tick_d;
        end
    end

    assign bus.led  = pat_q;
    assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: step-index reference model checked every cycle, plus
// directed sequences with literal LED values and tick spacings.
module tb_led_pattern_gen;

    localparam int N_LED      = 4;
    localparam int TICK_BASE  = 4;
    localparam int SPEED_BITS = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    led_pattern_if #(.N_LED(N_LED), .SPEED_BITS(SPEED_BITS)) bus_if ();

    led_pattern_gen #(
        .N_LED      (N_LED),
        .TICK_BASE  (TICK_BASE),
        .SPEED_BITS (SPEED_BITS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: prescaler count, selected mode and number of steps k taken since the
    // last mode load; the LED value is a closed-form function of (mode, k).
    int m_cnt;
    int m_k;
    int m_mode;
    bit m_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            m_k    <= 0;
            m_mode <= 0;
            m_tick <= 1'b0;
        end else if (int'(bus_if.mode) != m_mode) begin
            m_mode <= int'(bus_if.mode);
            m_k    <= 0;
            m_cnt  <= 0;
            m_tick <= 1'b0;
        end else if (bus_if.pause) begin
            m_tick <= 1'b0;
        end else if (m_cnt >= (TICK_BASE << bus_if.speed) - 1) begin
            m_cnt  <= 0;
            m_tick <= 1'b1;
            m_k    <= m_k + 1;
        end else begin
            m_cnt  <= m_cnt + 1;
            m_tick <= 1'b0;
        end
    end

    function automatic int model_led(input int mode, input int k);
        int p;
        int r;
        case (mode)
            0: r = k % (1 << N_LED);
            1: r = 1 << (k % N_LED);
            2: begin
                if (N_LED == 1) begin
                    r = 1;
                end else begin
                    p = k % (2 * N_LED - 2);
                    if (p >= N_LED) p = 2 * N_LED - 2 - p;
                    r = 1 << p;
                end
            end
            default: r = (k % 2 == 1) ? (1 << N_LED) - 1 : 0;
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        chk("model led", int'(bus_if.led), model_led(m_mode, m_k));
        chk("model tick", int'(bus_if.tick), int'(m_tick));
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus_if.tick && n < budget);
        if (!bus_if.tick) begin
            vectors++;
            miscompares++;
            $display("FAIL tick timeout: got no tick in %0d cycles, expected one", budget);
        end
    endtask

    task automatic tick_step(input string name, input int exp_gap, input int exp_led);
        int n;
        wait_tick(exp_gap + 4, n);
        chk({name, " gap"}, n, exp_gap);
        chk({name, " led"}, int'(bus_if.led), exp_led);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by %0t, expected earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int walk_exp[4]   = '{2, 4, 8, 1};
        int bounce_exp[7] = '{2, 4, 8, 4, 2, 1, 2};
        int hold;

        rst_n         = 1'b0;
        bus_if.mode   = 2'd0;
        bus_if.speed  = '0;
        bus_if.pause  = 1'b0;
        #12;
        chk("reset led", int'(bus_if.led), 0);
        chk("reset tick", int'(bus_if.tick), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 16; i++) tick_step("count", 4, i % 16);

        bus_if.mode = 2'd1;
        cyc();
        chk("walk load led", int'(bus_if.led), 1);
        chk("walk load tick", int'(bus_if.tick), 0);
        for (int i = 0; i < 4; i++) tick_step("walk", 4, walk_exp[i]);

        bus_if.mode = 2'd2;
        cyc();
        chk("bounce load led", int'(bus_if.led), 1);
        for (int i = 0; i < 7; i++) tick_step("bounce", 4, bounce_exp[i]);

        bus_if.speed = 2'd2;
        tick_step("slow", 16, 4);
        repeat (10) cyc();
        bus_if.speed = 2'd0;
        tick_step("speed drop", 1, 8);
        tick_step("fast again", 4, 4);

        cyc();
        hold = int'(bus_if.led);
        bus_if.pause = 1'b1;
        repeat (20) begin
            cyc();
            chk("pause led", int'(bus_if.led), hold);
            chk("pause tick", int'(bus_if.tick), 0);
        end
        bus_if.pause = 1'b0;
        tick_step("resume", 3, 2);

        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset led", int'(bus_if.led), 0);
        chk("async reset tick", int'(bus_if.tick), 0);
        @(negedge clk);
        bus_if.mode = 2'd3;
        rst_n       = 1'b1;
        cyc();
        chk("blink load led", int'(bus_if.led), 0);
        tick_step("blink on", 4, 15);
        tick_step("blink off", 4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
